fifo_resp: RTL and testbench

- Responder end of the pop/push protocol driven by the router arbiter: one queue that accepts push and pop strobes and reports empty/full status back.
- Instantiated eight times: four ingress queues, which the arbiter pops, and four egress queues, which the arbiter pushes.
- Read data is registered, so the word popped in one cycle is on data_out in the next cycle. That is the cycle in which the arbiter samples the destination field.

---
 rtl/fifo_resp.sv | 81 ++++++++
 tb/tb_fifo_resp.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fifo_resp.sv
// fifo_resp: responder queue for the arbiter pop/push protocol.
// Registered read data with combinational occupancy flags decoded from count.
module fifo_resp #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2,
    parameter int AF_LEVEL   = 3,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  error
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_C    = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_C    = AE_LEVEL[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_q, valid_d, error_q, error_d;
    logic                  push_ok, pop_ok;

    assign empty        = count_q == '0;
    assign full         = count_q == DEPTH_C;
    assign almost_empty = (count_q != '0) && (count_q <= AE_C);
    assign almost_full  = count_q >= AF_C;
    assign count        = count_q;
    assign data_out     = data_out_q;
    assign valid_out    = valid_q;
    assign error        = error_q;

    // A full queue still accepts a push when a pop frees a slot in the same cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = (push_ok && !pop_ok) ? count_q + 1'b1 :
                     (pop_ok && !push_ok) ? count_q - 1'b1 : count_q;
        data_out_d = pop_ok ? mem_q[rd_ptr_q] : data_out_q;
        valid_d    = pop_ok;
        error_d    = error_q | (push & ~push_ok) | (pop & empty);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    // Storage is not cleared; writes are blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (reset && push_ok)
            mem_q[wr_ptr_q] <= data_in;
    end
endmodule

// File: tb/tb_fifo_resp.sv
// tb_fifo_resp: directed self-checking bench for fifo_resp.
module tb_fifo_resp;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       push = 1'b0;
    logic [5:0] data_in = '0;
    logic       pop = 1'b0;
    logic [5:0] data_out;
    logic       valid_out, empty, full, almost_empty, almost_full, error;
    logic [2:0] count;
    int checks = 0;
    int failures = 0;

    fifo_resp dut (
        .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
        .data_out(data_out), .valid_out(valid_out), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
        .error(error)
    );

    always #5 clk = ~clk;

    task automatic step(input logic p, input logic [5:0] d, input logic r);
        push = p;
        data_in = d;
        pop = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1'b0, 6'h00, 1'b0);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(1'b1, 6'h3F, 1'b1);
        step(1'b1, 6'h3F, 1'b1);
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", error); end
        checks++; if (data_out !== 6'h00) begin failures++; $display("FAIL reset_data got=%0h exp=0", data_out); end
        checks++; if ({almost_empty, almost_full} !== 2'b00) begin failures++; $display("FAIL reset_almost got=%b exp=00", {almost_empty, almost_full}); end
        reset = 1'b1;
    endtask

    task automatic test_fill();
        logic [5:0] vals [4] = '{6'h05, 6'h1A, 6'h2F, 6'h33};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, vals[i], 1'b0);
            checks++; if (count !== 3'(i + 1)) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
            checks++; if (almost_full !== (i >= 2)) begin failures++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, almost_full, i >= 2); end
            checks++; if (full !== (i == 3)) begin failures++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, i == 3); end
            checks++; if (almost_empty !== (i == 0)) begin failures++; $display("FAIL fill_ae[%0d] got=%b exp=%b", i, almost_empty, i == 0); end
            checks++; if (empty !== 1'b0) begin failures++; $display("FAIL fill_empty[%0d] got=%b exp=0", i, empty); end
        end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL fill_error got=%b exp=0", error); end
    endtask

    task automatic test_overflow_drain();
        logic [5:0] vals [4] = '{6'h05, 6'h1A, 6'h2F, 6'h33};
        step(1'b1, 6'h3F, 1'b0);
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", count); end
        checks++; if (error !== 1'b1) begin failures++; $display("FAIL ovf_error got=%b exp=1", error); end
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL ovf_valid got=%b exp=0", valid_out); end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 6'h00, 1'b1);
            checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL drain_valid[%0d] got=%b exp=1", i, valid_out); end
            checks++; if (data_out !== vals[i]) begin failures++; $display("FAIL drain_data[%0d] got=%0h exp=%0h", i, data_out, vals[i]); end
            checks++; if (count !== 3'(3 - i)) begin failures++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, count, 3 - i); end
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", empty); end
    endtask

    task automatic test_underflow();
        step(1'b0, 6'h00, 1'b1);
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL unf_valid got=%b exp=0", valid_out); end
        checks++; if (data_out !== 6'h33) begin failures++; $display("FAIL unf_hold got=%0h exp=33", data_out); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL unf_count got=%0d exp=0", count); end
        checks++; if (error !== 1'b1) begin failures++; $display("FAIL unf_error got=%b exp=1", error); end
        do_reset();
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL unf_clear got=%b exp=0", error); end
        step(1'b1, 6'h11, 1'b1);
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL pp_empty_count got=%0d exp=1", count); end
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL pp_empty_valid got=%b exp=0", valid_out); end
        checks++; if (error !== 1'b1) begin failures++; $display("FAIL pp_empty_error got=%b exp=1", error); end
        step(1'b0, 6'h00, 1'b1);
        checks++; if (data_out !== 6'h11 || valid_out !== 1'b1) begin failures++; $display("FAIL pp_empty_pop got=%0h/%b exp=11/1", data_out, valid_out); end
    endtask

    task automatic test_simultaneous();
        logic [5:0] exp_tail [2] = '{6'h22, 6'h2A};
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, 6'(i), 1'b0);
        step(1'b1, 6'h22, 1'b1);
        checks++; if (data_out !== 6'h01 || valid_out !== 1'b1) begin failures++; $display("FAIL sim_full_data got=%0h/%b exp=1/1", data_out, valid_out); end
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL sim_full_count got=%0d exp=4", count); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL sim_full_error got=%b exp=0", error); end
        step(1'b0, 6'h00, 1'b1);
        step(1'b0, 6'h00, 1'b1);
        checks++; if (data_out !== 6'h03 || count !== 3'd2) begin failures++; $display("FAIL sim_pop2 got=%0h/%0d exp=3/2", data_out, count); end
        step(1'b1, 6'h2A, 1'b1);
        checks++; if (data_out !== 6'h04 || count !== 3'd2) begin failures++; $display("FAIL sim_mid got=%0h/%0d exp=4/2", data_out, count); end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 6'h00, 1'b1);
            checks++; if (data_out !== exp_tail[i]) begin failures++; $display("FAIL sim_tail[%0d] got=%0h exp=%0h", i, data_out, exp_tail[i]); end
        end
        checks++; if (empty !== 1'b1 || error !== 1'b0) begin failures++; $display("FAIL sim_end got=%b/%b exp=1/0", empty, error); end
    endtask

    task automatic test_wrap();
        logic [5:0] q [$];
        logic [5:0] e;
        do_reset();
        step(1'b1, 6'h10, 1'b0); q.push_back(6'h10);
        step(1'b1, 6'h11, 1'b0); q.push_back(6'h11);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 6'(6'h20 + i), 1'b1);
            q.push_back(6'(6'h20 + i));
            e = q.pop_front();
            checks++; if (data_out !== e || valid_out !== 1'b1) begin failures++; $display("FAIL wrap[%0d] got=%0h/%b exp=%0h/1", i, data_out, valid_out, e); end
            checks++; if (count !== 3'd2) begin failures++; $display("FAIL wrap_count[%0d] got=%0d exp=2", i, count); end
        end
        reset = 1'b0;
        step(1'b1, 6'h3C, 1'b1);
        reset = 1'b1;
        checks++; if (count !== 3'd0 || empty !== 1'b1 || valid_out !== 1'b0) begin failures++; $display("FAIL wrap_reset got=%0d/%b/%b exp=0/1/0", count, empty, valid_out); end
        step(1'b1, 6'h07, 1'b0);
        step(1'b0, 6'h00, 1'b1);
        checks++; if (data_out !== 6'h07 || empty !== 1'b1) begin failures++; $display("FAIL wrap_after got=%0h/%b exp=7/1", data_out, empty); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow_drain();
        test_underflow();
        test_simultaneous();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
